// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive bridge.
//   - rx_state_e      : receive FSM state encoding
//   - DATA_BITS       : payload bits per frame
//   - CLKS_PER_BIT_DEF: default bit period in clk cycles (50 MHz / 115200 baud)
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO for received bytes.
// The head entry is visible on rd_data_o whenever the FIFO is not empty;
// a read only advances the read pointer.
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   wr_en_i    : write request (honoured if not full, or if a read frees a slot)
//   wr_data_i  : write data
//   rd_en_i    : read request (ignored when empty)
//   rd_data_o  : head-of-FIFO data, 0 when empty
//   empty_o    : no entries
//   full_o     : DEPTH entries
//   count_o    : number of entries
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A write into a full FIFO is accepted when a read retires the head in
  // the same cycle: the write lands in the slot the read is vacating.
  assign do_pop  = rd_en_i & ~empty_o;
  assign do_push = wr_en_i & (~full_o | do_pop);

  // Gate to zero when empty so the output is defined after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_bridge.sv
// uart_rx_bridge: 8N1 UART receiver feeding a valid/ready byte stream
// through a small FIFO.
//   clk        : clock, all flops on rising edge
//   rstn       : asynchronous active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   data_out   : head-of-buffer byte
//   data_valid : data_out holds a valid byte
//   data_ready : consumer accepts the byte when high with data_valid
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : one-cycle pulse when a good byte is dropped (buffer full)
//   fifo_count : number of buffered bytes
//   busy       : FSM is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for rx_s low
// START | half a bit period into the start bit; re-check for glitch
// DATA  | sample one data bit per bit period, LSB first
// STOP  | sample stop bit after one bit period; write, drop or flag
module uart_rx_bridge
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                  sync1_q, sync2_q, rx_s;
  rx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  push, pop, fifo_full, fifo_empty;

  // Synchronizer flops reset high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  assign pop = data_valid & data_ready;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!fifo_full || pop) begin
            // A same-cycle pop frees the slot, so a full buffer still accepts.
            push = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .rd_en_i   (pop),
    .rd_data_o (data_out),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign data_valid = ~fifo_empty;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_bridge.sv
// tb_uart_rx_bridge: directed bench for uart_rx_bridge with an 8-clock bit
// period and a 4-entry buffer.
module tb_uart_rx_bridge;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;
  logic       busy;

  uart_rx_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int gi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted bytes, in the order the consumer takes them.
  logic [7:0] got [$];
  always @(posedge clk) begin
    if (data_valid && data_ready) got.push_back(data_out);
  end

  int   fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0, cnt_over = 0;
  int   vrun = 0, last_run = 0, last_rise = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, dv_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (frame_err && fe_prev) fe_wide <= fe_wide + 1;
    if (overrun && ov_prev)   ov_wide <= ov_wide + 1;
    fe_prev <= frame_err;
    ov_prev <= overrun;
    if (fifo_count > 3'(DEPTH)) cnt_over <= cnt_over + 1;
    if (data_valid) begin
      vrun <= vrun + 1;
    end else begin
      if (vrun != 0) last_run <= vrun;
      vrun <= 0;
    end
    if (data_valid && !dv_prev) last_rise <= cyc;
    dv_prev <= data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = 'x;
    if (gi < got.size()) obs = got[gi];
    gi++;
    check(tag, {24'd0, obs}, {24'd0, exp});
  endtask

  // Drives one 10-bit frame, one bit per CPB clocks. With pop_at_stop the
  // consumer is ready only on the stop-sample cycle (frame cycle 78).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      rx = bits[c / CPB];
      if (pop_at_stop) data_ready = (c == 78);
      @(posedge clk); #1;
    end
    rx = 1'b1;
  endtask

  int fe_base, ov_base, got_base;

  initial begin
    // Reset state
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out",   {24'd0, data_out}, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'h0);
    check("rst_frame_err",  {31'd0, frame_err}, 32'h0);
    check("rst_overrun",    {31'd0, overrun}, 32'h0);
    check("rst_busy",       {31'd0, busy}, 32'h0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'h0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Good frame 0xA5 with consumer ready
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_byte("a5_byte", 8'hA5);
    check("a5_latency", last_rise - start_cyc, 32'd79);
    check("a5_valid_len", last_run, 32'd1);
    check("a5_frame_err", fe_cnt, 32'd0);
    check("a5_overrun", ov_cnt, 32'd0);

    // Three-cycle low glitch on idle line
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    @(posedge clk); #1;
    check("glitch_busy_hi", {31'd0, busy}, 32'h1);
    repeat (12) @(posedge clk);
    #1;
    check("glitch_busy_lo", {31'd0, busy}, 32'h0);
    check("glitch_no_byte", got.size(), gi);
    check("glitch_no_fe", fe_cnt, 32'd0);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("ferr_count", fe_cnt, 32'd1);
    check("ferr_fifo", {29'd0, fifo_count}, 32'h0);
    check("ferr_no_byte", got.size(), gi);

    // Fill, overrun on the fifth, then drain in order
    data_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("fill_count", {29'd0, fifo_count}, 32'd4);
    check("fill_no_ov", ov_cnt, 32'd0);
    check("fill_head", {24'd0, data_out}, 32'h01);
    send_frame(8'h05, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ov_count", ov_cnt, 32'd1);
    check("ov_fifo", {29'd0, fifo_count}, 32'd4);
    check("ov_head_stable", {24'd0, data_out}, 32'h01);
    data_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_byte("drain_0", 8'h01);
    check_byte("drain_1", 8'h02);
    check_byte("drain_2", 8'h03);
    check_byte("drain_3", 8'h04);
    check("drain_empty", {29'd0, fifo_count}, 32'd0);

    // Reset during bit 4 of a frame, with a byte buffered
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    begin
      logic [9:0] pb;
      pb = {1'b1, 8'h7E, 1'b0};
      for (int c = 0; c < 5 * CPB + 4; c++) begin
        rx = pb[c / CPB];
        @(posedge clk); #1;
      end
    end
    check("mid_busy", {31'd0, busy}, 32'h1);
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_count", {29'd0, fifo_count}, 32'h0);
    check("mid_rst_valid", {31'd0, data_valid}, 32'h0);
    check("mid_rst_data",  {24'd0, data_out}, 32'h0);
    check("mid_rst_busy",  {31'd0, busy}, 32'h0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_fe", fe_cnt, fe_base);
    check("mid_no_ov", ov_cnt, ov_base);
    data_ready = 1'b1;
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_byte("after_rst_7e", 8'h7E);

    // Full buffer, pop coincides with the stop sample of 0x99
    data_ready = 1'b0;
    send_frame(8'hA1, 1'b1, 1'b0);
    send_frame(8'hA2, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA4, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("full_count", {29'd0, fifo_count}, 32'd4);
    ov_base = ov_cnt;
    send_frame(8'h99, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("pushpop_no_ov", ov_cnt, ov_base);
    check("pushpop_count", {29'd0, fifo_count}, 32'd4);
    check_byte("pushpop_pop", 8'hA1);
    data_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_byte("pushpop_0", 8'hA2);
    check_byte("pushpop_1", 8'hA3);
    check_byte("pushpop_2", 8'hA4);
    check_byte("pushpop_3", 8'h99);
    check("pushpop_empty", {29'd0, fifo_count}, 32'd0);

    // Break: line held low for 234 clocks gives three frame errors, no byte
    fe_base  = fe_cnt;
    ov_base  = ov_cnt;
    got_base = got.size();
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (234) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("break_fe", fe_cnt - fe_base, 32'd3);
    check("break_no_ov", ov_cnt, ov_base);
    check("break_no_byte", got.size(), got_base);
    check("break_idle", {31'd0, busy}, 32'h0);

    // Whole-run invariants
    check("fe_one_cycle", fe_wide, 32'd0);
    check("ov_one_cycle", ov_wide, 32'd0);
    check("count_bound", cnt_over, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
